// File: rtl/layer_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : layer_addr_sequencer
// Brief   : Streams per-layer weight/bias and input BRAM read addresses; layer
//           bases are derived at elaboration from the per-layer word counts.
// Rev     : 1.0  initial release
// ============================================================================
module layer_addr_sequencer #(
  parameter int unsigned              NUM_LAYERS = 3,
  parameter int unsigned              ADDR_W     = 10,
  parameter int unsigned              IN_ADDR_W  = 10,
  parameter logic [16*NUM_LAYERS-1:0] W_WORDS    = {16'd20, 16'd20, 16'd784},
  parameter int unsigned              WBASE      = 0,
  parameter int unsigned              INBASE     = 0,
  parameter int unsigned              LW         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 run_all,
  input  logic [LW-1:0]        start_layer,
  input  logic                 next_layer,
  input  logic                 abort,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic [ADDR_W-1:0]    w_addr,
  output logic [IN_ADDR_W-1:0] in_addr,
  output logic                 is_bias,
  output logic                 last_in_layer,
  output logic [LW-1:0]        layer_idx,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 done
);

  function automatic int unsigned f_words(int unsigned l);
    return 32'(W_WORDS[16*l +: 16]);
  endfunction

  // Each layer occupies its weight words followed by one bias word.
  function automatic int unsigned f_base(int unsigned l);
    int unsigned s;
    s = WBASE;
    for (int unsigned j = 0; j < l; j++) s = s + f_words(j) + 1;
    return s;
  endfunction

  function automatic bit f_words_bad();
    bit bad;
    bad = 1'b0;
    for (int unsigned j = 0; j < NUM_LAYERS; j++)
      if (f_words(j) == 0 || 64'(f_words(j)) >= (64'd1 << IN_ADDR_W)) bad = 1'b1;
    return bad;
  endfunction

  localparam int unsigned c_end        = f_base(NUM_LAYERS);
  localparam int unsigned c_tab        = 1 << LW;
  localparam logic [LW-1:0] c_last_layer = LW'(NUM_LAYERS - 1);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || NUM_LAYERS > c_tab) begin : g_err_layers
    $error("layer_addr_sequencer: NUM_LAYERS out of range");
  end
  if (64'(c_end) > (64'd1 << ADDR_W)) begin : g_err_addr
    $error("layer_addr_sequencer: final bias address does not fit in ADDR_W");
  end
  if (f_words_bad()) begin : g_err_words
    $error("layer_addr_sequencer: weight-word count zero or too wide for IN_ADDR_W");
  end

  // Tables padded to the full layer-index range so lookups need no bounds logic.
  logic [ADDR_W-1:0] c_base [c_tab];
  logic [ADDR_W-1:0] c_wcnt [c_tab];
  for (genvar l = 0; l < c_tab; l++) begin : g_tab
    if (l < NUM_LAYERS) begin : g_used
      assign c_base[l] = ADDR_W'(f_base(l));
      assign c_wcnt[l] = ADDR_W'(f_words(l));
    end else begin : g_unused
      assign c_base[l] = '0;
      assign c_wcnt[l] = '0;
    end
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WGT   = 3'd1,
    S_BIAS  = 3'd2,
    S_LWAIT = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            r_state, w_state_nx;
  logic [LW-1:0]     r_layer, w_layer_nx;
  logic [ADDR_W-1:0] r_k, w_k_nx;
  logic              r_run_all, w_run_all_nx;
  logic              r_nl_pend, w_nl_pend_nx;
  logic              r_layer_done, w_layer_done_nx;
  logic [LW-1:0]     w_start_cl;

  assign w_start_cl = (32'(start_layer) > NUM_LAYERS - 1) ? c_last_layer : start_layer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_k          <= '0;
      r_run_all    <= 1'b0;
      r_nl_pend    <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_layer      <= w_layer_nx;
      r_k          <= w_k_nx;
      r_run_all    <= w_run_all_nx;
      r_nl_pend    <= w_nl_pend_nx;
      r_layer_done <= w_layer_done_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_layer_nx      = r_layer;
    w_k_nx          = r_k;
    w_run_all_nx    = r_run_all;
    w_nl_pend_nx    = r_nl_pend;
    w_layer_done_nx = 1'b0;
    addr_valid      = 1'b0;
    w_addr          = '0;
    in_addr         = '0;
    is_bias         = 1'b0;
    last_in_layer   = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy         = 1'b0;
        w_nl_pend_nx = 1'b0;
        if (start) begin
          w_run_all_nx = run_all;
          w_layer_nx   = w_start_cl;
          w_k_nx       = '0;
          w_state_nx   = S_WGT;
        end
      end
      S_WGT: begin
        addr_valid = 1'b1;
        w_addr     = c_base[r_layer] + r_k;
        in_addr    = IN_ADDR_W'(INBASE) + IN_ADDR_W'(r_k);
        if (addr_ready) begin
          w_k_nx = r_k + ADDR_W'(1);
          if (r_k == c_wcnt[r_layer] - ADDR_W'(1)) w_state_nx = S_BIAS;
        end
      end
      S_BIAS: begin
        // k already equals W_L here, so k-1 repeats the last weight's input address.
        addr_valid    = 1'b1;
        w_addr        = c_base[r_layer] + c_wcnt[r_layer];
        in_addr       = IN_ADDR_W'(INBASE) + IN_ADDR_W'(r_k - ADDR_W'(1));
        is_bias       = 1'b1;
        last_in_layer = 1'b1;
        if (addr_ready) begin
          w_layer_done_nx = 1'b1;
          if (r_run_all && r_layer != c_last_layer) begin
            w_state_nx   = S_LWAIT;
            w_nl_pend_nx = next_layer;
          end else begin
            w_state_nx = S_FIN;
          end
        end
      end
      S_LWAIT: begin
        if (next_layer || r_nl_pend) begin
          w_layer_nx   = r_layer + LW'(1);
          w_k_nx       = '0;
          w_nl_pend_nx = 1'b0;
          w_state_nx   = S_WGT;
        end
      end
      S_FIN: begin
        // busy is released in the same cycle done is raised.
        busy       = 1'b0;
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (abort) begin
      w_state_nx      = S_IDLE;
      w_layer_done_nx = 1'b0;
      w_nl_pend_nx    = 1'b0;
    end
  end

  assign layer_done = r_layer_done;
  assign layer_idx  = r_layer;

endmodule
`default_nettype wire

// File: tb/tb_layer_addr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for layer_addr_sequencer: scoreboard of expected beats checked on every transfer.
module tb_layer_addr_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 0, run_all = 0, next_layer = 0, abort = 0, addr_ready = 0;
  logic [2:0] start_layer = 0;
  logic       addr_valid, is_bias, last_in_layer, busy, layer_done, done;
  logic [9:0] w_addr, in_addr;
  logic [2:0] layer_idx;

  logic       start2 = 0, run_all2 = 0, next2 = 0, abort2 = 0, ready2 = 0;
  logic [2:0] start_layer2 = 0;
  logic       valid2, is_bias2, last2, busy2, ld2, done2;
  logic [9:0] w_addr2, in_addr2;
  logic [2:0] layer_idx2;

  layer_addr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_all(run_all),
    .start_layer(start_layer), .next_layer(next_layer), .abort(abort),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .w_addr(w_addr),
    .in_addr(in_addr), .is_bias(is_bias), .last_in_layer(last_in_layer),
    .layer_idx(layer_idx), .busy(busy), .layer_done(layer_done), .done(done)
  );

  layer_addr_sequencer #(
    .NUM_LAYERS(2), .W_WORDS({16'd3, 16'd1}), .WBASE('h10)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .run_all(run_all2),
    .start_layer(start_layer2), .next_layer(next2), .abort(abort2),
    .addr_valid(valid2), .addr_ready(ready2), .w_addr(w_addr2),
    .in_addr(in_addr2), .is_bias(is_bias2), .last_in_layer(last2),
    .layer_idx(layer_idx2), .busy(busy2), .layer_done(ld2), .done(done2)
  );

  typedef struct packed {
    logic [9:0] w;
    logic [9:0] in;
    logic       bias;
    logic [2:0] lyr;
  } beat_t;

  int    n_checks = 0, n_fail = 0, n_xfer = 0, n_ld = 0, n_done = 0;
  beat_t sb[$];
  beat_t prev_beat;
  logic  prev_stall = 1'b0;

  int tb_words[3] = '{784, 20, 20};
  int tb_base[3]  = '{'h000, 'h311, 'h326};

  // Scoreboard comparator: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t cur, exp_b;
    cur = {w_addr, in_addr, is_bias, layer_idx};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (addr_valid) begin
        n_checks++;
        if (last_in_layer !== is_bias) begin
          n_fail++;
          $display("FAIL last_in_layer: got %b required %b", last_in_layer, is_bias);
        end
        if (prev_stall) begin
          n_checks++;
          if (cur !== prev_beat) begin
            n_fail++;
            $display("FAIL hold_stable: got %h required %h", cur, prev_beat);
          end
        end
        if (addr_ready && !abort) begin
          n_xfer++;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got w_addr=%h, required no beat", w_addr);
          end else begin
            exp_b = sb.pop_front();
            if (cur !== exp_b) begin
              n_fail++;
              $display("FAIL beat: got w=%h in=%h bias=%b layer=%0d required w=%h in=%h bias=%b layer=%0d",
                       cur.w, cur.in, cur.bias, cur.lyr, exp_b.w, exp_b.in, exp_b.bias, exp_b.lyr);
            end
          end
        end
      end
      prev_stall = addr_valid && !addr_ready && !abort;
      prev_beat  = cur;
      if (layer_done) n_ld++;
      if (done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_layer(input int l);
    beat_t b;
    for (int k = 0; k < tb_words[l]; k++) begin
      b = {10'(tb_base[l] + k), 10'(k), 1'b0, 3'(l)};
      sb.push_back(b);
    end
    b = {10'(tb_base[l] + tb_words[l]), 10'(tb_words[l] - 1), 1'b1, 3'(l)};
    sb.push_back(b);
  endtask

  task automatic do_start(input logic ra, input logic [2:0] sl);
    run_all = ra; start_layer = sl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit pulse_next,
                             output int lwait_cycles, output bit timed_out);
    int cyc;
    cyc = 0; lwait_cycles = 0; timed_out = 1'b0;
    while (!done) begin
      if (cyc >= budget) begin timed_out = 1'b1; break; end
      if (busy && !addr_valid) begin
        lwait_cycles++;
        next_layer = pulse_next;
      end else begin
        next_layer = 1'b0;
      end
      tick();
      cyc++;
    end
    next_layer = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({addr_valid, w_addr, in_addr, is_bias, last_in_layer, layer_idx} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_beat: got %h required 0", {addr_valid, w_addr, in_addr, is_bias, last_in_layer, layer_idx});
    end
    n_checks++;
    if ({busy, layer_done, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 000", {busy, layer_done, done});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b required 0 0", addr_valid, busy);
    end
  endtask

  task automatic test_run_all();
    int lw, ld0, d0, x0;
    bit to;
    ld0 = n_ld; d0 = n_done; x0 = n_xfer;
    addr_ready = 1'b1;
    push_layer(0); push_layer(1); push_layer(2);
    do_start(1'b1, 3'd0);
    n_checks++;
    if (addr_valid !== 1'b1 || w_addr !== 10'h000) begin
      n_fail++;
      $display("FAIL first_beat_latency: got valid=%b w=%h required 1 000", addr_valid, w_addr);
    end
    run_to_done(3000, 1'b1, lw, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL run_all_timeout: got no done, required done"); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b required 0", busy); end
    tick();
    n_checks++;
    if (n_ld - ld0 != 3 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL run_all_pulses: got layer_done=%0d done=%0d required 3 1", n_ld - ld0, n_done - d0);
    end
    n_checks++;
    if (n_xfer - x0 != 827 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL run_all_beats: got %0d left=%0d required 827 left=0", n_xfer - x0, sb.size());
    end
    n_checks++;
    if (lw != 2) begin n_fail++; $display("FAIL run_all_lwait: got %0d required 2", lw); end
  endtask

  task automatic test_single_layer(input logic [2:0] sl);
    int lw, ld0, d0, x0;
    bit to;
    ld0 = n_ld; d0 = n_done; x0 = n_xfer;
    addr_ready = 1'b1;
    push_layer(2);
    do_start(1'b0, sl);
    run_to_done(200, 1'b1, lw, to);
    tick();
    n_checks++;
    if (to || lw != 0) begin
      n_fail++;
      $display("FAIL single_layer_flow sl=%0d: got timeout=%b lwait=%0d required 0 0", sl, to, lw);
    end
    n_checks++;
    if (n_xfer - x0 != 21 || sb.size() != 0 || n_ld - ld0 != 1 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL single_layer_count sl=%0d: got beats=%0d left=%0d ld=%0d done=%0d required 21 0 1 1",
               sl, n_xfer - x0, sb.size(), n_ld - ld0, n_done - d0);
    end
  endtask

  task automatic test_random_ready();
    int cyc, x0, d0;
    x0 = n_xfer; d0 = n_done;
    push_layer(2);
    do_start(1'b0, 3'd2);
    cyc = 0;
    while (!done && cyc < 400) begin
      addr_ready = 1'($urandom_range(0, 1));
      // a start while busy must be ignored
      if (cyc == 5) begin start = 1'b1; run_all = 1'b1; start_layer = 3'd0; end
      else start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0; addr_ready = 1'b1;
    tick();
    n_checks++;
    if (cyc >= 400 || n_xfer - x0 != 21 || sb.size() != 0 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL random_ready: got beats=%0d left=%0d done=%0d required 21 0 1",
               n_xfer - x0, sb.size(), n_done - d0);
    end
  endtask

  task automatic test_lwait();
    int cyc, lw, ld0;
    bit to;
    ld0 = n_ld;
    addr_ready = 1'b1;
    push_layer(0); push_layer(1); push_layer(2);
    do_start(1'b1, 3'd0);
    cyc = 0;
    while (!(addr_valid && is_bias) && cyc < 2000) begin tick(); cyc++; end
    n_checks++;
    if (cyc >= 2000) begin n_fail++; $display("FAIL lwait_bias0_timeout: got no bias beat, required one"); end
    tick();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (addr_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL lwait_hold cycle %0d: got valid=%b busy=%b required 0 1", i, addr_valid, busy);
      end
      tick();
    end
    next_layer = 1'b1;
    tick();
    next_layer = 1'b0;
    n_checks++;
    if (addr_valid !== 1'b1 || w_addr !== 10'h311) begin
      n_fail++;
      $display("FAIL lwait_resume: got valid=%b w=%h required 1 311", addr_valid, w_addr);
    end
    cyc = 0;
    while (!(addr_valid && is_bias) && cyc < 100) begin tick(); cyc++; end
    next_layer = 1'b1;
    tick();
    next_layer = 1'b0;
    n_checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL coincident_lwait: got valid=%b busy=%b required 0 1", addr_valid, busy);
    end
    tick();
    n_checks++;
    if (addr_valid !== 1'b1 || w_addr !== 10'h326) begin
      n_fail++;
      $display("FAIL coincident_resume: got valid=%b w=%h required 1 326", addr_valid, w_addr);
    end
    run_to_done(100, 1'b0, lw, to);
    tick();
    n_checks++;
    if (to || sb.size() != 0 || n_ld - ld0 != 3) begin
      n_fail++;
      $display("FAIL lwait_end: got timeout=%b left=%0d ld=%0d required 0 0 3", to, sb.size(), n_ld - ld0);
    end
  endtask

  task automatic test_abort();
    int cyc, x0, d0, ld0, lw;
    bit to;
    addr_ready = 1'b1;
    push_layer(0);
    do_start(1'b1, 3'd0);
    x0 = n_xfer; d0 = n_done; ld0 = n_ld;
    cyc = 0;
    while (n_xfer - x0 < 100 && cyc < 500) begin tick(); cyc++; end
    n_checks++;
    if (w_addr !== 10'd100) begin n_fail++; $display("FAIL abort_beat100: got %h required 064", w_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got valid=%b busy=%b required 0 0", addr_valid, busy);
    end
    repeat (5) tick();
    n_checks++;
    if (n_done != d0 || n_ld != ld0 || n_xfer - x0 != 100) begin
      n_fail++;
      $display("FAIL abort_pulses: got done=%0d ld=%0d beats=%0d required 0 0 100",
               n_done - d0, n_ld - ld0, n_xfer - x0);
    end
    sb.delete();
    push_layer(0);
    do_start(1'b0, 3'd0);
    n_checks++;
    if (addr_valid !== 1'b1 || w_addr !== 10'h000) begin
      n_fail++;
      $display("FAIL abort_restart: got valid=%b w=%h required 1 000", addr_valid, w_addr);
    end
    run_to_done(1500, 1'b0, lw, to);
    tick();
    n_checks++;
    if (to || sb.size() != 0 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL abort_restart_end: got timeout=%b left=%0d done=%0d required 0 0 1", to, sb.size(), n_done - d0);
    end
  endtask

  task automatic test_reset_mid();
    addr_ready = 1'b1;
    push_layer(0);
    do_start(1'b1, 3'd0);
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({addr_valid, w_addr, in_addr, is_bias, last_in_layer, layer_idx, busy, layer_done, done} !== 28'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b w=%h in=%h busy=%b required all 0", addr_valid, w_addr, in_addr, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    tick();
    n_checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got valid=%b busy=%b required 0 0", addr_valid, busy);
    end
  endtask

  task automatic test_override();
    logic [9:0] exp_w[6]  = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
    logic [9:0] exp_in[6] = '{0, 0, 0, 1, 2, 2};
    logic       exp_b[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int idx, cyc;
    ready2 = 1'b1; next2 = 1'b1; run_all2 = 1'b1; start_layer2 = 3'd0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    idx = 0; cyc = 0;
    while (!done2 && cyc < 50) begin
      if (valid2) begin
        n_checks++;
        if (idx >= 6 || w_addr2 !== exp_w[idx] || in_addr2 !== exp_in[idx] || is_bias2 !== exp_b[idx]) begin
          n_fail++;
          $display("FAIL override_beat %0d: got w=%h in=%h bias=%b", idx, w_addr2, in_addr2, is_bias2);
        end
        idx++;
      end
      tick();
      cyc++;
    end
    next2 = 1'b0;
    n_checks++;
    if (cyc >= 50 || idx != 6) begin
      n_fail++;
      $display("FAIL override_count: got %0d beats required 6", idx);
    end
  endtask

  initial begin
    test_reset();
    test_run_all();
    test_single_layer(3'd2);
    test_single_layer(3'd7);
    test_random_ready();
    test_lwait();
    test_abort();
    test_reset_mid();
    test_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
